uart_rx: RTL and testbench

- UART serial receiver; consumer of the 16x-oversampling tick from the team's baud-rate generator.
- Samples the asynchronous `rx` line and detects the start bit. Assembles DBIT data bits, LSB first, then checks the stop bit.
- Presents the received word with a one-cycle done strobe and a framing-error flag. Sits between the board RX pin and the RX FIFO / host logic.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver. Reports the data word with a done
//            strobe and a framing-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int             c_NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]     c_SB_LAST = 5'(SB_TICK - 1);
  localparam logic [c_NW-1:0] c_N_LAST = c_NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic [4:0]        r_s_cnt, w_s_cnt_next;
  logic [c_NW-1:0]   r_n_cnt, w_n_cnt_next;
  logic [DBIT-1:0]   r_b_reg, w_b_next;
  logic              r_frame_err, w_ferr_next;
  logic              r_done, w_done_next;
  logic              r_sync1, r_rx_s;

  // Both synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= IDLE;
      r_s_cnt     <= '0;
      r_n_cnt     <= '0;
      r_b_reg     <= '0;
      r_frame_err <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_rx_s      <= r_sync1;
      r_state     <= w_state_next;
      r_s_cnt     <= w_s_cnt_next;
      r_n_cnt     <= w_n_cnt_next;
      r_b_reg     <= w_b_next;
      r_frame_err <= w_ferr_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_cnt_next = r_s_cnt;
    w_n_cnt_next = r_n_cnt;
    w_b_next     = r_b_reg;
    w_ferr_next  = r_frame_err;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_next = START;
          w_s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s_cnt == 5'd7) begin
            if (!r_rx_s) begin
              w_state_next = DATA;
              w_s_cnt_next = '0;
              w_n_cnt_next = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s_cnt == 5'd15) begin
            w_s_cnt_next = '0;
            w_b_next     = {r_rx_s, r_b_reg[DBIT-1:1]};
            if (r_n_cnt == c_N_LAST) w_state_next = STOP;
            else                     w_n_cnt_next = r_n_cnt + 1'b1;
          end else begin
            w_s_cnt_next = r_s_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s_cnt == c_SB_LAST) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
            w_ferr_next  = ~r_rx_s;
          end else begin
            w_s_cnt_next = r_s_cnt + 5'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign dout         = r_b_reg;
  assign rx_done_tick = r_done;
  assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx (8N1 instance and 7-bit/2-stop).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BITCLK = 64;   // s_tick every 4 clk, 16 ticks per bit
  localparam int LAT    = 152;  // ticks from falling edge to done: 8 + 8*16 + 16
  localparam int LAT_LO = LAT * 4 - 4;
  localparam int LAT_HI = LAT * 4 + 8;

  logic       clk = 1'b0;
  logic       reset, rx, rx7, s_tick;
  logic [7:0] dout;
  logic       rx_done_tick, frame_err;
  logic [6:0] dout7;
  logic       done7, ferr7;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] q_data[$];
  logic       q_ferr[$];
  int         q_cyc[$];
  logic [6:0] q7_data[$];
  logic       q7_ferr[$];
  int         q7_cyc[$];

  uart_rx dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .rx(rx7), .s_tick(s_tick),
    .dout(dout7), .rx_done_tick(done7), .frame_err(ferr7)
  );

  always #5 clk = ~clk;

  initial begin : g_tickgen
    int d;
    d = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      d = (d + 1) % 4;
      s_tick = (d == 0);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rx_done_tick) begin
      q_data.push_back(dout);
      q_ferr.push_back(frame_err);
      q_cyc.push_back(cyc);
    end
    if (done7) begin
      q7_data.push_back(dout7);
      q7_ferr.push_back(ferr7);
      q7_cyc.push_back(cyc);
    end
  end

  task automatic drive(input bit which, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which) rx7 = v;
      else       rx  = v;
    end
  endtask

  // Bad stop bit is held low only past its mid-bit sample so the resulting
  // false start resolves as a glitch before the next frame.
  task automatic send_frame(input bit which, input logic [7:0] data, input int nbits,
                            input bit good_stop, input int stop_bits, output int t_start);
    @(negedge clk);
    t_start = cyc;
    if (which) rx7 = 1'b0;
    else       rx  = 1'b0;
    drive(which, 1'b0, BITCLK - 1);
    for (int i = 0; i < nbits; i++) drive(which, data[i], BITCLK);
    if (good_stop) drive(which, 1'b1, BITCLK * stop_bits);
    else begin
      drive(which, 1'b0, 40);
      drive(which, 1'b1, BITCLK - 40);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; rx7 = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout actual=%h expected=00", dout); end
    checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr actual=%b expected=0", frame_err); end
    checks++; if (dout7 !== 7'h00) begin failures++; $display("FAIL reset_dout7 actual=%h expected=00", dout7); end
    reset = 1'b0;
    drive(0, 1'b1, 2 * BITCLK);
  endtask

  task automatic test_valid_frame();
    int n0, t0;
    n0 = q_data.size();
    send_frame(0, 8'hA5, 8, 1'b1, 1, t0);
    drive(0, 1'b1, BITCLK);
    checks++;
    if (q_data.size() != n0 + 1) begin
      failures++; $display("FAIL a5_done_count actual=%0d expected=%0d", q_data.size() - n0, 1);
    end else begin
      checks++; if (q_data[n0] !== 8'hA5) begin failures++; $display("FAIL a5_dout actual=%h expected=a5", q_data[n0]); end
      checks++; if (q_ferr[n0] !== 1'b0) begin failures++; $display("FAIL a5_ferr actual=%b expected=0", q_ferr[n0]); end
      checks++;
      if (q_cyc[n0] - t0 < LAT_LO || q_cyc[n0] - t0 > LAT_HI) begin
        failures++; $display("FAIL a5_latency actual=%0d expected=%0d..%0d", q_cyc[n0] - t0, LAT_LO, LAT_HI);
      end
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = q_data.size();
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 3 * BITCLK);
    checks++; if (q_data.size() != n0) begin failures++; $display("FAIL glitch_no_done actual=%0d expected=0", q_data.size() - n0); end
    checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL glitch_dout actual=%h expected=a5", dout); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL glitch_ferr actual=%b expected=0", frame_err); end
  endtask

  task automatic test_framing_err();
    int n0, t0;
    n0 = q_data.size();
    send_frame(0, 8'h3C, 8, 1'b0, 1, t0);
    drive(0, 1'b1, BITCLK);
    checks++;
    if (q_data.size() != n0 + 1) begin
      failures++; $display("FAIL ferr_done_count actual=%0d expected=1", q_data.size() - n0);
    end else begin
      checks++; if (q_data[n0] !== 8'h3C) begin failures++; $display("FAIL ferr_dout actual=%h expected=3c", q_data[n0]); end
      checks++; if (q_ferr[n0] !== 1'b1) begin failures++; $display("FAIL ferr_flag actual=%b expected=1", q_ferr[n0]); end
    end
    drive(0, 1'b1, 2 * BITCLK);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_hold actual=%b expected=1", frame_err); end
    send_frame(0, 8'h3C, 8, 1'b1, 1, t0);
    drive(0, 1'b1, BITCLK);
    checks++;
    if (q_data.size() != n0 + 2) begin
      failures++; $display("FAIL ferr_clear_count actual=%0d expected=2", q_data.size() - n0);
    end else begin
      checks++; if (q_ferr[n0+1] !== 1'b0) begin failures++; $display("FAIL ferr_clear actual=%b expected=0", q_ferr[n0+1]); end
    end
  endtask

  task automatic test_back_to_back();
    int n0, t0, t1;
    n0 = q_data.size();
    send_frame(0, 8'h00, 8, 1'b1, 1, t0);
    send_frame(0, 8'hFF, 8, 1'b1, 1, t1);
    drive(0, 1'b1, BITCLK);
    checks++;
    if (q_data.size() != n0 + 2) begin
      failures++; $display("FAIL b2b_count actual=%0d expected=2", q_data.size() - n0);
    end else begin
      checks++; if (q_data[n0] !== 8'h00 || q_ferr[n0] !== 1'b0) begin failures++; $display("FAIL b2b_first actual=%h/%b expected=00/0", q_data[n0], q_ferr[n0]); end
      checks++; if (q_data[n0+1] !== 8'hFF || q_ferr[n0+1] !== 1'b0) begin failures++; $display("FAIL b2b_second actual=%h/%b expected=ff/0", q_data[n0+1], q_ferr[n0+1]); end
      checks++; if (q_cyc[n0+1] - q_cyc[n0] != 160 * 4) begin failures++; $display("FAIL b2b_spacing actual=%0d expected=%0d", q_cyc[n0+1] - q_cyc[n0], 640); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int n0, t0;
    d = 8'h5A;
    n0 = q_data.size();
    drive(0, 1'b0, BITCLK);
    for (int i = 0; i < 3; i++) drive(0, d[i], BITCLK);
    @(negedge clk);
    reset = 1'b1; rx = 1'b1;
    #1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rstmid_dout actual=%h expected=00", dout); end
    checks++; if (frame_err !== 1'b0 || rx_done_tick !== 1'b0) begin failures++; $display("FAIL rstmid_flags actual=%b%b expected=00", frame_err, rx_done_tick); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b1, 2 * BITCLK);
    checks++; if (q_data.size() != n0) begin failures++; $display("FAIL rstmid_no_done actual=%0d expected=0", q_data.size() - n0); end
    send_frame(0, 8'h81, 8, 1'b1, 1, t0);
    drive(0, 1'b1, BITCLK);
    checks++;
    if (q_data.size() != n0 + 1) begin
      failures++; $display("FAIL rstmid_81_count actual=%0d expected=1", q_data.size() - n0);
    end else begin
      checks++; if (q_data[n0] !== 8'h81) begin failures++; $display("FAIL rstmid_81 actual=%h expected=81", q_data[n0]); end
    end
  endtask

  task automatic test_dbit7();
    int n0, t0;
    n0 = q7_data.size();
    send_frame(1, 8'h55, 7, 1'b1, 2, t0);
    drive(1, 1'b1, BITCLK);
    checks++;
    if (q7_data.size() != n0 + 1) begin
      failures++; $display("FAIL d7_count actual=%0d expected=1", q7_data.size() - n0);
    end else begin
      checks++; if (q7_data[n0] !== 7'h55) begin failures++; $display("FAIL d7_dout actual=%h expected=55", q7_data[n0]); end
      checks++; if (q7_ferr[n0] !== 1'b0) begin failures++; $display("FAIL d7_ferr actual=%b expected=0", q7_ferr[n0]); end
      // 8 start ticks + 7 data bits * 16 + 32 stop ticks
      checks++;
      if (q7_cyc[n0] - t0 < (8 + 7*16 + 32) * 4 - 4 || q7_cyc[n0] - t0 > (8 + 7*16 + 32) * 4 + 8) begin
        failures++; $display("FAIL d7_latency actual=%0d expected=%0d", q7_cyc[n0] - t0, (8 + 7*16 + 32) * 4);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ed[$];
    logic       ef[$];
    int         ts[$];
    int base, t, gap;
    logic [7:0] d;
    bit good;
    base = q_data.size();
    for (int f = 0; f < 8; f++) begin
      d = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      gap = good ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(0, d, 8, good, 1, t);
      ed.push_back(d); ef.push_back(!good); ts.push_back(t);
      drive(0, 1'b1, gap * BITCLK);
    end
    drive(0, 1'b1, BITCLK);
    checks++;
    if (q_data.size() != base + 8) begin
      failures++; $display("FAIL rnd_count actual=%0d expected=8", q_data.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_data[base+i] !== ed[i] || q_ferr[base+i] !== ef[i]) begin
          failures++; $display("FAIL rnd_frame%0d actual=%h/%b expected=%h/%b", i, q_data[base+i], q_ferr[base+i], ed[i], ef[i]);
        end
        checks++;
        if (q_cyc[base+i] - ts[i] < LAT_LO || q_cyc[base+i] - ts[i] > LAT_HI) begin
          failures++; $display("FAIL rnd_latency%0d actual=%0d expected=%0d..%0d", i, q_cyc[base+i] - ts[i], LAT_LO, LAT_HI);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_glitch();
    test_framing_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_dbit7();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
